// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its cache.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package inst_fetch_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int INST_WIDTH       = 32;
    localparam int ICACHE_SIZE      = 16;
    localparam int ICACHE_IDX_WIDTH = 4;
    // Instructions are word aligned, so the two low address bits carry no information.
    localparam int ICACHE_TAG_WIDTH = ADDR_WIDTH - ICACHE_IDX_WIDTH - 2;

    typedef logic [ADDR_WIDTH-1:0]       addr_t;
    typedef logic [INST_WIDTH-1:0]       inst_t;
    typedef logic [ICACHE_IDX_WIDTH-1:0] idx_t;
    typedef logic [ICACHE_TAG_WIDTH-1:0] tag_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DISCARD  = 2'd2
    } fetch_state_e;

    // Instruction queue push payload.
    typedef struct packed {
        inst_t inst;
        addr_t pc;
    } iq_pkt_t;

    // Sequential fetch, no prediction; wraps naturally at the top of the address space.
    function automatic addr_t next_pc(input addr_t pc);
        return pc + ADDR_WIDTH'(4);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bundles the fetch unit's queue, memory and flush signals.
// Latency: n/a (wiring only).
// Backpressure: iq_full_iq_in stalls pushes; req_mem_out is held until rdy_mem_in.
// master = fetch unit side, slave = instruction queue / memory / ROB side.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic  iq_full_iq_in;
    inst_t inst_iq_out;
    addr_t pc_iq_out;
    logic  rdy_inst_iq_out;
    logic  req_mem_out;
    addr_t addr_mem_out;
    inst_t inst_mem_in;
    logic  rdy_mem_in;
    logic  refresh_rob_cdb_in;
    addr_t target_pc_rob_in;

    modport master (
        input  iq_full_iq_in,
        input  inst_mem_in,
        input  rdy_mem_in,
        input  refresh_rob_cdb_in,
        input  target_pc_rob_in,
        output inst_iq_out,
        output pc_iq_out,
        output rdy_inst_iq_out,
        output req_mem_out,
        output addr_mem_out
    );

    modport slave (
        output iq_full_iq_in,
        output inst_mem_in,
        output rdy_mem_in,
        output refresh_rob_cdb_in,
        output target_pc_rob_in,
        input  inst_iq_out,
        input  pc_iq_out,
        input  rdy_inst_iq_out,
        input  req_mem_out,
        input  addr_mem_out
    );

endinterface

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one instruction per line, index addr[5:2], tag addr[31:6].
// Latency: read is combinational (same cycle); write lands on the next posedge.
// Backpressure: none; a write is accepted every cycle wr_en is high.
// Ports: clk_in/rst_in, rd_addr -> rd_hit/rd_data, wr_en/wr_addr/wr_data fill port.
module inst_fetch_icache
    import inst_fetch_pkg::*;
(
    input  logic  clk_in,
    input  logic  rst_in,
    input  addr_t rd_addr,
    output logic  rd_hit,
    output inst_t rd_data,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  inst_t wr_data
);

    logic [ICACHE_SIZE-1:0] valid_q;
    logic [ICACHE_SIZE-1:0] valid_d;
    tag_t                   tag_q  [ICACHE_SIZE];
    inst_t                  data_q [ICACHE_SIZE];

    idx_t rd_idx;
    tag_t rd_tag;
    idx_t wr_idx;
    tag_t wr_tag;

    assign rd_idx = rd_addr[ICACHE_IDX_WIDTH+1:2];
    assign rd_tag = rd_addr[ADDR_WIDTH-1:ICACHE_IDX_WIDTH+2];
    assign wr_idx = wr_addr[ICACHE_IDX_WIDTH+1:2];
    assign wr_tag = wr_addr[ADDR_WIDTH-1:ICACHE_IDX_WIDTH+2];

    // Byte-offset bits are always zero for aligned fetches.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{rd_addr[1:0], wr_addr[1:0]};

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Only the valid bits need a reset; tag/data are don't-care until validated.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Sequential instruction fetch: PC, fetch FSM and miss handling in front of a direct-mapped icache.
// Latency: hit pushes the cycle after lookup; miss penalty = memory latency + 2 cycles.
// Backpressure: iq_full_iq_in stalls the PC and pushes; rdy_in low freezes all state.
// Ports: clk_in, rst_in (sync, active-high), rdy_in (global enable), bus (inst_fetch_if.master).
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    inst_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    addr_t        pc_q, pc_d;
    logic         req_q, req_d;
    addr_t        addr_q, addr_d;
    logic         push_q, push_d;
    iq_pkt_t      pkt_q, pkt_d;
    logic         cache_we;
    logic         cache_wr_en;
    logic         hit;
    inst_t        hit_data;

    assign cache_wr_en = cache_we && !rst_in;

    inst_fetch_icache u_icache (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_addr (pc_q),
        .rd_hit  (hit),
        .rd_data (hit_data),
        .wr_en   (cache_wr_en),
        .wr_addr (addr_q),
        .wr_data (bus.inst_mem_in)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        pkt_d    = pkt_q;
        // The push is a strobe: it drops after one cycle, including while frozen.
        push_d   = 1'b0;
        cache_we = 1'b0;

        if (rdy_in) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A flush wins over a hit in the same cycle.
                    if (bus.refresh_rob_cdb_in) begin
                        pc_d = bus.target_pc_rob_in;
                    end else if (!bus.iq_full_iq_in) begin
                        if (hit) begin
                            push_d     = 1'b1;
                            pkt_d.inst = hit_data;
                            pkt_d.pc   = pc_q;
                            pc_d       = next_pc(pc_q);
                        end else begin
                            req_d   = 1'b1;
                            addr_d  = pc_q;
                            state_d = ST_MEM_WAIT;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    // The fill is never dropped: a line fetched before a flush is still a
                    // correct line, it just is not pushed. The later hit delivers it.
                    if (bus.refresh_rob_cdb_in) begin
                        pc_d = bus.target_pc_rob_in;
                    end
                    if (bus.rdy_mem_in) begin
                        cache_we = 1'b1;
                        req_d    = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (bus.refresh_rob_cdb_in) begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (bus.refresh_rob_cdb_in) begin
                        pc_d = bus.target_pc_rob_in;
                    end
                    if (bus.rdy_mem_in) begin
                        cache_we = 1'b1;
                        req_d    = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            push_q  <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            push_q  <= push_d;
            pkt_q   <= pkt_d;
        end
    end

    assign bus.rdy_inst_iq_out = push_q;
    assign bus.inst_iq_out     = pkt_q.inst;
    assign bus.pc_iq_out       = pkt_q.pc;
    assign bus.req_mem_out     = req_q;
    assign bus.addr_mem_out    = addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table for the corner cases, then randomized traffic
// checked against a program-order / cache-content reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_inst_fetch;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, rdy, full, refr;
        logic [31:0] tgt;
        logic        mv;
        logic [31:0] md;
        logic        e_push;
        logic [31:0] e_inst, e_pc;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, rdy, full, refr, input logic [31:0] tgt,
                                input logic mv, input logic [31:0] md,
                                input logic e_push, input logic [31:0] e_inst, e_pc,
                                input logic e_req, input logic [31:0] e_addr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.full = full; v.refr = refr; v.tgt = tgt;
        v.mv = mv; v.md = md; v.e_push = e_push; v.e_inst = e_inst; v.e_pc = e_pc;
        v.e_req = e_req; v.e_addr = e_addr;
        tbl.push_back(v);
    endfunction

    // Memory image used by the random phase.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference cache: 16 lines of one word, line = word address mod 16, tag = address / 64.
    logic        m_val [16];
    logic [31:0] m_tag [16];

    function automatic logic m_hit(input logic [31:0] a);
        int i;
        i = int'((a / 4) % 16);
        return m_val[i] && (m_tag[i] == a / 64);
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        int i;
        i = int'((a / 4) % 16);
        m_val[i] = 1'b1;
        m_tag[i] = a / 64;
    endfunction

    task automatic drive(input logic rst, rdy, full, refr, input logic [31:0] tgt,
                         input logic mv, input logic [31:0] md);
        rst_in                 = rst;
        rdy_in                 = rdy;
        bus.iq_full_iq_in      = full;
        bus.refresh_rob_cdb_in = refr;
        bus.target_pc_rob_in   = tgt;
        bus.rdy_mem_in         = mv;
        bus.inst_mem_in        = md;
    endtask

    localparam logic [31:0] I0 = 32'h0000_0013;
    localparam logic [31:0] I4 = 32'h0010_0093;
    localparam logic [31:0] I8 = 32'h0020_0113;
    localparam logic [31:0] IC = 32'h0030_0193;

    // Random-phase state.
    logic [31:0] exp_pc, o_addr, p_tgt, p_md;
    logic        o_req, p_rdy, p_full, p_ref, p_mv;
    logic        s_push, s_req;
    logic [31:0] s_inst, s_pc, s_addr;
    int          cnt, n_push;

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

        // rst rdy full ref tgt           mv md             push inst          pc             req addr
        add(1, 1, 0, 0, 0,            0, 0,            0, 0,            0,            0, 0);            // v0 reset
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 0);            // v1 miss at 0
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 0);
        add(0, 1, 0, 0, 0,            1, I0,           0, 0,            0,            0, 0);            // v4 fill
        add(0, 1, 0, 0, 0,            0, 0,            1, I0,           0,            0, 0);            // v5 push 0
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'h4);
        add(0, 1, 0, 0, 0,            1, I4,           0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, I4,           32'h4,        0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'h8);
        add(0, 1, 0, 0, 0,            1, I8,           0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, I8,           32'h8,        0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'hC);
        add(0, 1, 0, 0, 0,            1, IC,           0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, IC,           32'hC,        0, 0);            // v14
        add(0, 1, 0, 1, 0,            0, 0,            0, 0,            0,            0, 0);            // v15 loop back
        add(0, 1, 0, 0, 0,            0, 0,            1, I0,           0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, I4,           32'h4,        0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, I8,           32'h8,        0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, IC,           32'hC,        0, 0);            // v19
        add(0, 1, 0, 1, 0,            0, 0,            0, 0,            0,            0, 0);            // v20
        add(0, 1, 0, 0, 0,            0, 0,            1, I0,           0,            0, 0);
        add(0, 1, 1, 0, 0,            0, 0,            0, 0,            0,            0, 0);            // v22 queue full
        add(0, 1, 1, 0, 0,            0, 0,            0, 0,            0,            0, 0);
        add(0, 1, 1, 0, 0,            0, 0,            0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, I4,           32'h4,        0, 0);            // v25 resume
        add(0, 1, 0, 0, 0,            0, 0,            1, I8,           32'h8,        0, 0);
        add(0, 1, 0, 1, 32'h40,       0, 0,            0, 0,            0,            0, 0);            // v27 alias
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'h40);
        add(0, 1, 0, 0, 0,            1, 32'hAAAA0040, 0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, 32'hAAAA0040, 32'h40,       0, 0);
        add(0, 1, 0, 1, 0,            0, 0,            0, 0,            0,            0, 0);            // v31
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 0);            // 0 evicted
        add(0, 1, 0, 0, 0,            1, I0,           0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, I0,           0,            0, 0);            // v34
        add(1, 1, 0, 0, 0,            0, 0,            0, 0,            0,            0, 0);            // v35 reset
        add(0, 1, 0, 1, 32'h8,        0, 0,            0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'h8);
        add(0, 1, 0, 1, 32'h100,      0, 0,            0, 0,            0,            1, 32'h8);        // v38 discard
        add(0, 1, 0, 0, 0,            1, 32'h88,       0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'h100);
        add(0, 1, 0, 0, 0,            1, 32'h1001,     0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, 32'h1001,     32'h100,      0, 0);
        add(0, 1, 0, 1, 32'h8,        0, 0,            0, 0,            0,            0, 0);            // v43
        add(0, 1, 0, 0, 0,            0, 0,            1, 32'h88,       32'h8,        0, 0);            // 8 was filled
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'hC);        // v45
        add(0, 0, 0, 0, 0,            1, 32'hDEAD,     0, 0,            0,            1, 32'hC);        // v46 frozen
        add(0, 0, 0, 1, 32'h200,      0, 0,            0, 0,            0,            1, 32'hC);
        add(0, 0, 0, 0, 0,            1, 32'hDEAD,     0, 0,            0,            1, 32'hC);
        add(0, 0, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'hC);
        add(0, 0, 0, 0, 0,            1, 32'hDEAD,     0, 0,            0,            1, 32'hC);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'hC);        // v51
        add(0, 1, 0, 0, 0,            1, 32'hCC,       0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, 32'hCC,       32'hC,        0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'h10);       // v54
        add(1, 1, 0, 0, 0,            0, 0,            0, 0,            0,            0, 0);            // v55 reset mid-miss
        add(0, 1, 0, 0, 0,            1, 32'hBAD,      0, 0,            0,            1, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 0);
        add(0, 1, 0, 0, 0,            1, I0,           0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, I0,           0,            0, 0);            // v59
        add(0, 1, 0, 1, 32'hFFFFFFFC, 0, 0,            0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'hFFFFFFFC);
        add(0, 1, 0, 0, 0,            1, 32'hF0F0,     0, 0,            0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, 32'hF0F0,     32'hFFFFFFFC, 0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            1, I0,           0,            0, 0);            // v64 wrapped
        add(0, 1, 0, 1, 0,            0, 0,            0, 0,            0,            0, 0);
        add(0, 1, 0, 1, 0,            0, 0,            0, 0,            0,            0, 0);            // v66 flush beats hit
        add(0, 1, 0, 0, 0,            0, 0,            1, I0,           0,            0, 0);
        add(0, 1, 0, 0, 0,            0, 0,            0, 0,            0,            1, 32'h4);
        add(0, 1, 0, 1, 32'h4,        1, 32'h44,       0, 0,            0,            0, 0);            // v69
        add(0, 1, 0, 0, 0,            0, 0,            1, 32'h44,       32'h4,        0, 0);

        @(negedge clk_in);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].full, tbl[i].refr, tbl[i].tgt, tbl[i].mv, tbl[i].md);
            @(posedge clk_in);
            @(negedge clk_in);
            chk($sformatf("v%0d.push", i), 32'(bus.rdy_inst_iq_out), 32'(tbl[i].e_push));
            chk($sformatf("v%0d.req", i), 32'(bus.req_mem_out), 32'(tbl[i].e_req));
            if (tbl[i].e_push || tbl[i].rst) begin
                chk($sformatf("v%0d.inst", i), bus.inst_iq_out, tbl[i].e_inst);
                chk($sformatf("v%0d.pc", i), bus.pc_iq_out, tbl[i].e_pc);
            end
            if (tbl[i].e_req || tbl[i].rst) begin
                chk($sformatf("v%0d.addr", i), bus.addr_mem_out, tbl[i].e_addr);
            end
        end

        // Randomized phase.
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        @(posedge clk_in);
        @(negedge clk_in);
        exp_pc = '0;
        for (int i = 0; i < 16; i++) begin
            m_val[i] = 1'b0;
            m_tag[i] = '0;
        end
        o_req = 1'b0; o_addr = '0;
        p_rdy = 1'b1; p_full = 1'b0; p_ref = 1'b0; p_tgt = '0; p_mv = 1'b0; p_md = '0;
        cnt = 0; n_push = 0;
        drive(1'b0, p_rdy, p_full, p_ref, p_tgt, p_mv, p_md);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            s_push = bus.rdy_inst_iq_out;
            s_inst = bus.inst_iq_out;
            s_pc   = bus.pc_iq_out;
            s_req  = bus.req_mem_out;
            s_addr = bus.addr_mem_out;

            if (!p_rdy) begin
                chk("hold.push", 32'(s_push), 32'd0);
                chk("hold.req", 32'(s_req), 32'(o_req));
                chk("hold.addr", s_addr, o_addr);
            end
            if (s_req && o_req) begin
                chk("addr.stable", s_addr, o_addr);
            end
            if (s_push) begin
                n_push++;
                chk("push.gate", 32'({p_rdy, p_ref, p_full}), 32'b100);
                chk("push.pc", s_pc, exp_pc);
                chk("push.inst", s_inst, memfn(exp_pc));
                chk("push.hit", 32'(m_hit(exp_pc)), 32'd1);
                exp_pc = exp_pc + 32'd4;
            end
            if (s_req && !o_req) begin
                chk("req.gate", 32'({p_rdy, p_ref, p_full}), 32'b100);
                chk("req.addr", s_addr, exp_pc);
                chk("req.miss", 32'(m_hit(exp_pc)), 32'd0);
            end
            if (p_rdy && p_ref) begin
                exp_pc = p_tgt;
            end
            if (p_rdy && p_mv && o_req) begin
                m_fill(o_addr);
                chk("fill.drop", 32'(s_req), 32'd0);
            end
            o_req  = s_req;
            o_addr = s_addr;

            p_rdy  = ($urandom_range(0, 9) != 0);
            p_full = ($urandom_range(0, 3) == 0);
            p_ref  = ($urandom_range(0, 24) == 0);
            p_tgt  = $urandom_range(0, 127) << 2;
            if (s_req) begin
                if (cnt == 0) begin
                    p_mv = 1'b1;
                    p_md = memfn(s_addr);
                end else begin
                    cnt--;
                    p_mv = 1'b0;
                    p_md = $urandom;
                end
            end else begin
                cnt  = $urandom_range(0, 3);
                p_mv = ($urandom_range(0, 7) == 0);
                p_md = $urandom;
            end
            drive(1'b0, p_rdy, p_full, p_ref, p_tgt, p_mv, p_md);
        end
        chk("liveness", 32'(n_push >= 50), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
